// File: rtl/microprocessor_pkg.sv
// Shared types and constants for the simplified microprocessor.
// Used by the step pulse generator and the instruction decoder.
package microprocessor_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SINGLE = 2'd1,
        HALTED = 2'd2
    } step_state_t;

    localparam logic [2:0] OPC_HALT = 3'b000;

    function automatic logic is_halt_opcode(input logic [2:0] opc);
        return opc == OPC_HALT;
    endfunction

    // Width needed for a counter that must be able to hold max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/step_pulse_generator_if.sv
// Board-side signals of the step pulse generator.
// The master is the board/decoder side, the slave is the generator.
interface step_pulse_generator_if;
    import microprocessor_pkg::*;

    logic        key_n;
    logic        step_mode;
    logic        halt_req;
    logic        step;
    logic        tick;
    logic        halted;
    logic        key_level;
    step_state_t state;

    modport master (
        output key_n, step_mode, halt_req,
        input  step, tick, halted, key_level, state
    );

    modport slave (
        input  key_n, step_mode, halt_req,
        output step, tick, halted, key_level, state
    );

endinterface

// File: rtl/step_pulse_generator_key_debouncer.sv
// Push-button synchroniser and debouncer; emits a one-cycle press strobe
// on each debounced release-to-press transition.
module key_debouncer
    import microprocessor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic press
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic [1:0]       primed;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    // Presses only count once a genuinely released key has been seen since
    // reset, so a key held through reset cannot produce a step.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            primed    <= '0;
            armed     <= 1'b0;
            cnt       <= '0;
            key_level <= 1'b1;
            press     <= 1'b0;
        end else begin
            sync1  <= key_n;
            sync2  <= sync1;
            primed <= {primed[0], 1'b1};
            press  <= 1'b0;

            if (primed[1] && sync2 && key_level)
                armed <= 1'b1;

            if (sync2 == key_level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                key_level <= sync2;
                cnt       <= '0;
                press     <= armed & ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/step_pulse_generator.sv
// Step strobe source for the simplified microprocessor: free-run divider,
// single-step key path and sticky halt. Optional macro STEP_AUTO_REPEAT_EN.
module step_pulse_generator
    import microprocessor_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned STEP_HZ         = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000
) (
    input  logic                    clock,
    input  logic                    reset,
    step_pulse_generator_if.slave   io
);

    localparam int unsigned TICK_DIV = CLK_HZ / STEP_HZ;
    localparam int unsigned DIV_W    = cnt_width(TICK_DIV - 1);

    if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1) begin : g_param_check
        $error("step_pulse_generator: TICK_DIV must be >= 2, delays must be >= 1");
    end

    logic             key_level_w;
    logic             press_w;
    logic [DIV_W-1:0] div_cnt;
    logic             tick_now;
    logic             tick_r;
    logic             step_r;
    logic             halted_r;
    logic             repeat_fire;
    step_state_t      state_r;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clock     (clock),
        .reset     (reset),
        .key_n     (io.key_n),
        .key_level (key_level_w),
        .press     (press_w)
    );

    assign tick_now = (div_cnt == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
            tick_r  <= 1'b0;
        end else begin
            tick_r  <= tick_now;
            div_cnt <= tick_now ? '0 : div_cnt + DIV_W'(1);
        end
    end

`ifdef STEP_AUTO_REPEAT_EN
    localparam int unsigned HOLD_W = cnt_width(REPEAT_DELAY);

    logic              holding;
    logic [HOLD_W-1:0] hold_cnt;

    // Hold timing starts at the press strobe, so a key that went low
    // without an accepted press never auto-repeats.
    always_ff @(posedge clock) begin
        if (reset || state_r != SINGLE || key_level_w) begin
            holding  <= 1'b0;
            hold_cnt <= '0;
        end else if (press_w) begin
            holding  <= 1'b1;
            hold_cnt <= '0;
        end else if (holding && hold_cnt != HOLD_W'(REPEAT_DELAY)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    assign repeat_fire = holding && (hold_cnt == HOLD_W'(REPEAT_DELAY))
                         && tick_now && !key_level_w;
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= RUN;
            step_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            step_r <= 1'b0;
            if (state_r == HALTED || io.halt_req) begin
                state_r  <= HALTED;
                halted_r <= 1'b1;
            end else begin
                case (state_r)
                    RUN: begin
                        step_r <= tick_now;
                        if (io.step_mode)
                            state_r <= SINGLE;
                    end
                    SINGLE: begin
                        step_r <= press_w | repeat_fire;
                        if (!io.step_mode)
                            state_r <= RUN;
                    end
                    default: begin
                        state_r  <= HALTED;
                        halted_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign io.step      = step_r;
    assign io.tick      = tick_r;
    assign io.halted    = halted_r;
    assign io.key_level = key_level_w;
    assign io.state     = state_r;

endmodule

// File: tb/tb_step_pulse_generator.sv
// Scoreboard bench for step_pulse_generator: stimulus queues expected
// step/tick cycles, a negedge monitor pops and compares them.
module tb_step_pulse_generator;
    import microprocessor_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;
    int   step_q[$];
    int   tick_q[$];

    step_pulse_generator_if io ();

    step_pulse_generator #(
        .CLK_HZ          (20),
        .STEP_HZ         (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (12)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    always #5 clock = ~clock;

    // Cycle k is the interval after the k-th rising edge with reset low.
    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (io.step !== 1'b0) begin
                if (step_q.size() == 0) check_val("step_unexpected", cyc, -1);
                else                    check_val("step_cycle", cyc, step_q.pop_front());
            end
            if (io.tick !== 1'b0) begin
                if (tick_q.size() == 0) check_val("tick_unexpected", cyc, -1);
                else                    check_val("tick_cycle", cyc, tick_q.pop_front());
            end
        end
    end

    task automatic wait_to(input int k);
        int guard = 0;
        while (cyc != k && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        if (cyc != k) check_val("wait_cycle", cyc, k);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_rst_step"},      int'(io.step),      0);
        check_val({tag, "_rst_tick"},      int'(io.tick),      0);
        check_val({tag, "_rst_halted"},    int'(io.halted),    0);
        check_val({tag, "_rst_key_level"}, int'(io.key_level), 1);
        check_val({tag, "_rst_state"},     int'(io.state),     int'(RUN));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        #1 reset = 1'b1;
        step_q.delete();
        tick_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_reset_values(tag);
    endtask

    task automatic push_ticks(input int last);
        for (int c = 10; c <= last; c += 10) tick_q.push_back(c);
    endtask

    task automatic end_test(input string tag);
        #1;
        check_val({tag, "_missing_steps"}, step_q.size(), 0);
        check_val({tag, "_missing_ticks"}, tick_q.size(), 0);
        step_q.delete();
        tick_q.delete();
    endtask

    initial begin
        io.key_n     = 1'b1;
        io.step_mode = 1'b0;
        io.halt_req  = 1'b0;

        // Free-run: step follows tick every 10 cycles
        do_reset("t1");
        push_ticks(30);
        step_q.push_back(10); step_q.push_back(20); step_q.push_back(30);
        wait_to(35);
        check_val("t1_state", int'(io.state), int'(RUN));
        check_val("t1_halted", int'(io.halted), 0);
        end_test("t1");

        // Single press, key low edges 5..14 -> one step at 12
        io.step_mode = 1'b1;
        do_reset("t2");
        push_ticks(20);
        step_q.push_back(12);
        wait_to(4);  io.key_n = 1'b0;
        wait_to(10); check_val("t2_level_before", int'(io.key_level), 1);
        wait_to(11); check_val("t2_level_pressed", int'(io.key_level), 0);
        wait_to(14); io.key_n = 1'b1;
        wait_to(25);
        check_val("t2_level_released", int'(io.key_level), 1);
        check_val("t2_state", int'(io.state), int'(SINGLE));
        end_test("t2");

        // Bouncing key: toggles every 2 cycles, never debounces
        do_reset("t3");
        push_ticks(20);
        for (int c = 4; c <= 25; c++) begin
            wait_to(c);
            check_val("t3_level_stable", int'(io.key_level), 1);
            io.key_n = (c < 20) ? logic'(((c - 4) / 2) % 2) : 1'b1;
        end
        end_test("t3");

        // Halt at cycle 15 suppresses step 20; sticky until reset
        io.step_mode = 1'b0;
        do_reset("t4");
        push_ticks(40);
        step_q.push_back(10);
        wait_to(15);
        check_val("t4_halted_before", int'(io.halted), 0);
        io.halt_req = 1'b1;
        wait_to(16);
        check_val("t4_halted_set", int'(io.halted), 1);
        check_val("t4_state_halted", int'(io.state), int'(HALTED));
        wait_to(20); io.halt_req = 1'b0;
        wait_to(22); io.key_n = 1'b0; io.step_mode = 1'b1;
        wait_to(32); io.key_n = 1'b1; io.step_mode = 1'b0;
        wait_to(40);
        check_val("t4_still_halted", int'(io.halted), 1);
        check_val("t4_state_sticky", int'(io.state), int'(HALTED));
        end_test("t4");
        do_reset("t4_exit");

        // Long hold: auto-repeat only when the macro is built in
        io.step_mode = 1'b1;
        do_reset("t5");
        push_ticks(60);
        step_q.push_back(12);
`ifdef STEP_AUTO_REPEAT_EN
        step_q.push_back(30);
        step_q.push_back(40);
`endif
        wait_to(4);  io.key_n = 1'b0;
        wait_to(42); io.key_n = 1'b1;
        wait_to(60);
        end_test("t5");

        // Key held across a mid-debounce reset must be released and re-pressed
        do_reset("t6");
        wait_to(1); io.key_n = 1'b0;
        wait_to(7);
        #1 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_val("t6_cyc_restart", cyc, 0);
        check_val("t6_level_after_reset", int'(io.key_level), 1);
        check_val("t6_step_after_reset", int'(io.step), 0);
        push_ticks(40);
        step_q.push_back(29);
        wait_to(8);  check_val("t6_level_held_low", int'(io.key_level), 0);
        wait_to(11); io.key_n = 1'b1;
        wait_to(21); check_val("t6_level_released", int'(io.key_level), 1);
        io.key_n = 1'b0;
        wait_to(28); check_val("t6_level_repressed", int'(io.key_level), 0);
        wait_to(33); io.key_n = 1'b1;
        wait_to(40);
        end_test("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
